// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared state encoding and requester indices for the SDRAM arbiter.
package sdram_arb_pkg;
    localparam int NPORTS     = 3;
    localparam int PORT_IOCTL = 0;
    localparam int PORT_CPU   = 1;
    localparam int PORT_VID   = 2;
    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
endpackage

// File: rtl/sdram_arb_pick.sv
// sdram_arb_pick: combinational grant decision; the loader always wins, CPU/video alternate.
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic [NPORTS-1:0] req,
    input  logic              rr,
    output logic [1:0]        gnt,
    output logic              valid
);
    // rr = 1 means the video port is preferred when CPU and video both ask
    always_comb begin
        valid = |req;
        gnt   = req[PORT_IOCTL]             ? 2'(PORT_IOCTL) :
                (req[PORT_CPU] && req[PORT_VID]) ? (rr ? 2'(PORT_VID) : 2'(PORT_CPU)) :
                req[PORT_CPU]               ? 2'(PORT_CPU) :
                req[PORT_VID]               ? 2'(PORT_VID) : 2'(PORT_IOCTL);
    end
endmodule

// File: rtl/sdram_arb.sv
// sdram_arb: three-requester arbiter in front of a single SDRAM controller port.
// Optional BUSY watchdog enabled by defining SDRAM_ARB_WDOG_EN.
module sdram_arb
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = 25,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk_ram,
    input  logic                       reset_n,
    input  logic [NPORTS-1:0]          p_req,
    input  logic [NPORTS-1:0]          p_we,
    input  logic [NPORTS*ADDR_W-1:0]   p_addr,
    input  logic [NPORTS*16-1:0]       p_wdata,
    input  logic [NPORTS*2-1:0]        p_be,
    output logic [NPORTS-1:0]          p_ack,
    output logic [15:0]                p_rdata,
    output logic                       ctl_req,
    output logic                       ctl_we,
    output logic [ADDR_W-1:0]          ctl_addr,
    output logic [15:0]                ctl_wdata,
    output logic [1:0]                 ctl_be,
    input  logic                       ctl_ack,
    input  logic [15:0]                ctl_rdata,
    output logic                       err
);
    state_t            state;
    logic [1:0]        gnt, gnt_q;
    logic              valid, rr;
    logic [ADDR_W-1:0] sel_addr;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("sdram_arb: TIMEOUT_CYC must be at least 1");
    end

    sdram_arb_pick u_pick (.req(p_req), .rr(rr), .gnt(gnt), .valid(valid));

    assign sel_addr = p_addr[gnt*ADDR_W +: ADDR_W];

`ifdef SDRAM_ARB_WDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk_ram or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            gnt_q     <= '0;
            rr        <= 1'b0;
            p_ack     <= '0;
            p_rdata   <= '0;
            ctl_req   <= 1'b0;
            ctl_we    <= 1'b0;
            ctl_addr  <= '0;
            ctl_wdata <= '0;
            ctl_be    <= '0;
`ifdef SDRAM_ARB_WDOG_EN
            cnt       <= '0;
            err       <= 1'b0;
`endif
        end else begin
            p_ack <= '0;
`ifdef SDRAM_ARB_WDOG_EN
            err   <= 1'b0;
`endif
            case (state)
                IDLE: if (valid) begin
                    gnt_q     <= gnt;
                    ctl_req   <= 1'b1;
                    ctl_we    <= p_we[gnt];
                    ctl_addr  <= sel_addr & ~ADDR_W'(1);
                    ctl_wdata <= p_wdata[gnt*16 +: 16];
                    ctl_be    <= p_be[gnt*2 +: 2];
                    if (gnt != 2'(PORT_IOCTL)) rr <= (gnt == 2'(PORT_CPU));
`ifdef SDRAM_ARB_WDOG_EN
                    cnt       <= '0;
`endif
                    state     <= BUSY;
                end
                BUSY: begin
                    if (ctl_ack) begin
                        ctl_req       <= 1'b0;
                        p_rdata       <= ctl_rdata;
                        p_ack[gnt_q]  <= 1'b1;
                        state         <= ACK;
                    end
`ifdef SDRAM_ARB_WDOG_EN
                    else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                        ctl_req       <= 1'b0;
                        p_rdata       <= 16'hDEAD;
                        p_ack[gnt_q]  <= 1'b1;
                        err           <= 1'b1;
                        state         <= ACK;
                    end else cnt <= cnt + 1'b1;
`endif
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sdram_arb.md
SDRAM_ARB -- requirements
Module: sdram_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, meaning the byte address width of all ports.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 64, meaning the watchdog limit in clk_ram cycles; used only when SDRAM_ARB_WDOG_EN is defined.
REQ-003 SHALL have port clk_ram, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port p_req, input, 3, request level per requester: 0 = ioctl loader, 1 = CPU, 2 = video.
REQ-006 SHALL have port p_we, input, 3, per-requester write enable (1 = write).
REQ-007 SHALL have port p_addr, input, 3xADDR_W, per-requester byte address; bit 0 is ignored.
REQ-008 SHALL have port p_wdata, input, 3x16, per-requester write data.
REQ-009 SHALL have port p_be, input, 3x2, per-requester byte enables; bit 1 is the high byte.
REQ-010 SHALL have port p_ack, output, 3, one-cycle completion pulse per requester.
REQ-011 SHALL have port p_rdata, output, 16, read data, valid while any p_ack bit is high.
REQ-012 SHALL have ports ctl_req, ctl_we, ctl_addr, ctl_wdata and ctl_be, outputs, 1/1/ADDR_W/16/2, the single SDRAM controller request.
REQ-013 SHALL have ports ctl_ack, input, 1, and ctl_rdata, input, 16; ctl_rdata is valid during the ctl_ack cycle.
REQ-014 SHALL have port err, output, 1, a one-cycle pulse on watchdog abort; tied to 0 when the watchdog is compiled out.

Function
REQ-015 SHALL implement a state machine with states IDLE, BUSY and ACK.
REQ-016 In IDLE, if any p_req bit is set, the block SHALL grant one port, latch that port's we/addr/wdata/be into the ctl_* registers, set ctl_req and enter BUSY on the next edge.
REQ-017 Grant priority SHALL be: port 0 always wins; otherwise ports 1 and 2 round-robin, with the port not granted last preferred; the round-robin pointer updates only on a grant to port 1 or 2.
REQ-018 In BUSY, ctl_req and all ctl_* fields SHALL stay constant until ctl_ack is sampled high.
REQ-019 On ctl_ack the block SHALL clear ctl_req, register ctl_rdata into p_rdata, pulse the granted port's p_ack for exactly one cycle (the ACK state), then return to IDLE.
REQ-020 No requests SHALL be sampled in ACK; a requester SHALL drop or change its p_req in the cycle after its p_ack.
REQ-021 Latency SHALL be one cycle from p_req sampled in IDLE to ctl_req high, and one cycle from ctl_ack to p_ack.
REQ-022 p_rdata SHALL hold its last value outside ack cycles; for writes p_rdata is don't-care.
REQ-023 p_req changes during BUSY SHALL NOT affect the transaction in flight, and deassertion during BUSY does not cancel it.
REQ-024 Address arithmetic SHALL be pass-through with no wrap or translation; ctl_addr bit 0 is forced to 0.

Reset
REQ-025 While reset_n is low: state = IDLE, ctl_req = 0, p_ack = 0, err = 0, p_rdata = 0, ctl_* = 0, and the round-robin pointer prefers port 1.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction with no p_ack; the controller is reset by the same reset_n.

Configuration
REQ-027 With SDRAM_ARB_WDOG_EN defined, a counter SHALL count cycles in BUSY; on reaching TIMEOUT_CYC without ctl_ack the block SHALL clear ctl_req, pulse err and the granted p_ack with p_rdata = 16'hDEAD, then go through ACK to IDLE.
REQ-028 Without SDRAM_ARB_WDOG_EN, BUSY SHALL wait indefinitely, err = 0, and no counter logic SHALL exist.

Structure
REQ-029 Package sdram_arb_pkg SHALL hold the state enum, the port-index constants (PORT_IOCTL = 0, PORT_CPU = 1, PORT_VID = 2) and NPORTS = 3.
REQ-030 The grant decision SHALL be a combinational sub-module sdram_arb_pick (inputs: req vector and rr pointer; outputs: grant index and valid).

Verification
REQ-031 Port 1 reads 0x000100 with the controller acking after 5 cycles with 0x1234 -> ctl_req high 1 cycle after the request, p_ack[1] high for 1 cycle, p_rdata = 0x1234.
REQ-032 Ports 1 and 2 requesting continuously for 4 transactions -> grant order 1, 2, 1, 2.
REQ-033 Ports 0, 1 and 2 all requesting, port 0 issuing 3 back-to-back writes -> all 3 port-0 writes are granted before port 1 or port 2.
REQ-034 Port 2 write with be = 2'b01 to addr 0x000003 -> ctl_addr = 0x000002, ctl_be = 01, ctl_we = 1.
REQ-035 reset_n pulsed low during BUSY -> ctl_req = 0 immediately, no p_ack, the next request is served normally.
REQ-036 With SDRAM_ARB_WDOG_EN and TIMEOUT_CYC = 8, the controller never acks -> err and p_ack pulse after 8 BUSY cycles with p_rdata = 16'hDEAD.
